// File: rtl/ofdm_sample_streamer.sv
// Preloaded complex-sample source for the OFDM receiver: streams buffer entries
// with a programmable idle gap, valid/ready handshake and optional looping.
module ofdm_sample_streamer #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 128,
    parameter int GAP_W  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_real_i,
    input  logic [WIDTH-1:0]  wr_imag_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              loop_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [GAP_W-1:0]  gap_i,
    input  logic              ready_i,
    output logic              en_o,
    output logic [WIDTH-1:0]  dout_real_o,
    output logic [WIDTH-1:0]  dout_imag_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int                LEN_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                loop_q, loop_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [GAP_W-1:0]    gcnt_q, gcnt_d;
    logic                stop_pend_q, stop_pend_d;
    logic [WIDTH-1:0]    dout_real_q, dout_imag_q;

    logic [2*WIDTH-1:0]  mem_q [DEPTH];
    logic                cap;
    logic [ADDR_W-1:0]   cap_idx;
    logic                last;

    // Sample storage is deliberately not reset; reads see pre-edge contents,
    // so a write and a capture at the same address in one cycle yield old data.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= {wr_real_i, wr_imag_i};
    end

    assign last = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        loop_d      = loop_q;
        gap_d       = gap_q;
        gcnt_d      = gcnt_q;
        stop_pend_d = stop_pend_q;
        cap         = 1'b0;
        cap_idx     = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (len_i != '0)) begin
                    state_d     = S_SEND;
                    idx_d       = '0;
                    len_d       = (len_i > DEPTH_L) ? DEPTH_L : len_i;
                    loop_d      = loop_i;
                    gap_d       = gap_i;
                    gcnt_d      = '0;
                    stop_pend_d = 1'b0;
                    cap         = 1'b1;
                    cap_idx     = '0;
                end
            end
            S_SEND: begin
                if (ready_i) begin
                    if (stop_i || stop_pend_q || (last && !loop_q)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = last ? '0 : idx_q + ADDR_W'(1);
                        if (gap_q != '0) begin
                            state_d = S_GAP;
                            gcnt_d  = gap_q;
                        end else begin
                            cap     = 1'b1;
                            cap_idx = idx_d;
                        end
                    end
                end
            end
            S_GAP: begin
                if (stop_i) stop_pend_d = 1'b1;
                // Capture on the final gap edge so writes earlier in the gap are seen.
                if (gcnt_q == GAP_W'(1)) begin
                    state_d = S_SEND;
                    gcnt_d  = '0;
                    cap     = 1'b1;
                    cap_idx = idx_q;
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            gap_q       <= '0;
            gcnt_q      <= '0;
            stop_pend_q <= 1'b0;
            dout_real_q <= '0;
            dout_imag_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            gap_q       <= gap_d;
            gcnt_q      <= gcnt_d;
            stop_pend_q <= stop_pend_d;
            if (cap) {dout_real_q, dout_imag_q} <= mem_q[cap_idx];
        end
    end

    assign en_o        = (state_q == S_SEND);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign dout_real_o = dout_real_q;
    assign dout_imag_o = dout_imag_q;

endmodule

// File: tb/tb_ofdm_sample_streamer.sv
// Directed + randomized bench for ofdm_sample_streamer; expected samples come
// from a shadow copy of the buffer and a per-acceptance timing model.
module tb_ofdm_sample_streamer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int GAP_W = 4;
    localparam int AW    = 3;

    logic             clk, rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_real, wr_imag;
    logic             start, stop, loop_s, ready;
    logic [AW:0]      len;
    logic [GAP_W-1:0] gap;
    logic             en, busy, done;
    logic [WIDTH-1:0] dout_real, dout_imag;

    logic [2*WIDTH-1:0] ref_mem [DEPTH];
    int n_pass = 0;
    int n_chk  = 0;

    ofdm_sample_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_real_i(wr_real), .wr_imag_i(wr_imag),
        .start_i(start), .stop_i(stop), .loop_i(loop_s), .len_i(len), .gap_i(gap),
        .ready_i(ready),
        .en_o(en), .dout_real_o(dout_real), .dout_imag_o(dout_imag),
        .busy_o(busy), .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] i);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_real = r; wr_imag = i;
        ref_mem[a] = {r, i};
        step();
        wr_en = 1'b0;
    endtask

    // rmode: 0 ready always high, 1 ready on alternate cycles, 2 random ready.
    task automatic stream(input string tag, input int n_len, input int g, input bit lp,
                          input int rmode, input int stop_at, input bit wr0,
                          input bit wrgap, input bit restart);
        int lenc    = (n_len > DEPTH) ? DEPTH : n_len;
        int exp_acc = (stop_at >= 0) ? stop_at + 1 : lenc;
        int acc = 0, c = 1, cl = -1, next_en = 1, n_en = 0, n_done = 0;
        bit stopped = 0, gw_done = 0, en_exp;
        logic [2*WIDTH-1:0] old0, last_v, exp_v;
        old0   = ref_mem[0];
        last_v = '0;
        start = 1'b1; len = n_len[AW:0]; gap = g[GAP_W-1:0]; loop_s = lp;
        if (wr0) begin
            wr_en = 1'b1; wr_addr = '0; {wr_real, wr_imag} = $urandom;
            ref_mem[0] = {wr_real, wr_imag};
        end
        step();
        len = '0; gap = '0; loop_s = 1'b0;
        forever begin
            wr_en = 1'b0; stop = 1'b0;
            start = (restart && c == 2);
            if (start) len = 1;
            if (rmode == 0)      ready = 1'b1;
            else if (rmode == 1) ready = (c % 2 == 0);
            else                 ready = 1'($urandom % 2);
            if (stop_at >= 0 && !stopped && acc == stop_at && busy && !en) begin
                stop = 1'b1; stopped = 1;
            end
            // First gap cycle after sample 0 is accepted: overwrite the next entry.
            if (wrgap && !gw_done && acc == 1 && busy && !en && !done) begin
                wr_en = 1'b1; wr_addr = AW'(1 % lenc); {wr_real, wr_imag} = $urandom;
                ref_mem[1 % lenc] = {wr_real, wr_imag};
                gw_done = 1;
            end
            @(negedge clk);
            en_exp = (cl < 0) && (c >= next_en);
            n_en   += int'(en);
            n_done += int'(done);
            check({tag, ".en"},   en,   en_exp);
            check({tag, ".busy"}, busy, (cl < 0) || (c <= cl + 1));
            check({tag, ".done"}, done, (cl >= 0) && (c == cl + 1));
            if (en_exp) begin
                exp_v = (acc == 0 && wr0) ? old0 : ref_mem[acc % lenc];
                check({tag, ".dout"}, {dout_real, dout_imag}, exp_v);
                if (ready) begin
                    last_v = exp_v; acc++; next_en = c + 1 + g;
                    if (acc == exp_acc) cl = c;
                end
            end else if (acc > 0 && cl < 0) begin
                check({tag, ".hold"}, {dout_real, dout_imag}, last_v);
            end
            step();
            c++;
            if (cl >= 0 && c > cl + 3) break;
            if (c > 3000) begin
                check({tag, ".timeout_acc"}, acc, exp_acc);
                break;
            end
        end
        start = 1'b0; stop = 1'b0; ready = 1'b0;
        check({tag, ".done_cnt"}, n_done, 1);
        if (rmode == 0) check({tag, ".en_cnt"}, n_en, exp_acc);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_real = '0; wr_imag = '0;
        start = 1'b0; stop = 1'b0; loop_s = 1'b0; ready = 1'b0; len = '0; gap = '0;
        #2;
        check("rst.en",   en,   1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.dout", {dout_real, dout_imag}, 32'h0);
        #10 rst_n = 1'b1;
        step();

        for (int k = 0; k < DEPTH; k++) wr(k, WIDTH'(k), WIDTH'(-k));

        stream("gap1",    8, 1, 1'b0, 0, -1, 1'b0, 1'b0, 1'b1);
        stream("alt_rdy", 8, 0, 1'b0, 1, -1, 1'b0, 1'b0, 1'b0);
        stream("loop3",   3, 2, 1'b1, 0,  4, 1'b0, 1'b0, 1'b0);

        start = 1'b1; len = '0; gap = 4'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("len0.busy", busy, 1'b0);
            check("len0.en",   en,   1'b0);
            step();
        end

        stream("clamp", 9, 0, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);

        start = 1'b1; len = 4'd8; gap = '0; ready = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("amid.en",   en,   1'b0);
        check("amid.busy", busy, 1'b0);
        check("amid.done", done, 1'b0);
        check("amid.dout", {dout_real, dout_imag}, 32'h0);
        #3 rst_n = 1'b1;
        step();
        @(negedge clk);
        check("post_rst.busy", busy, 1'b0);
        step();
        stream("replay", 8, 0, 1'b0, 0, -1, 1'b0, 1'b0, 1'b0);

        stream("wr_cap_gap", 4, 3, 1'b0, 0, -1, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < DEPTH; k++) wr(k, WIDTH'($urandom), WIDTH'($urandom));
        for (int r = 0; r < 6; r++) begin
            int rl = $urandom_range(1, 9);
            int rg = $urandom_range(0, 3);
            if (r % 2 == 1)
                stream("rnd_loop", rl, rg + 1, 1'b1, 2, $urandom_range(1, 10), 1'b0, 1'b0, 1'b0);
            else
                stream("rnd", rl, rg, 1'b0, 2, -1, 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ofdm_sample_streamer.md
# ofdm_sample_streamer

Synthesizable, parametrised complex-sample source for the FFT-OFDM receiver datapath. Holds up to DEPTH complex samples in an internal buffer, loaded through a write port, and streams them to the receiver `top` input with a programmable idle gap between samples, a valid/ready handshake, and optional looping. Used for on-chip self-test and FPGA bring-up, where the receiver is fed from a preloaded buffer rather than from the ADC front end.

## Interface
- `WIDTH`, 16: bit width of each real/imag component (signed two's complement)
- `DEPTH`, 128: sample buffer entries; power of two, ≥2
- `GAP_W`, 4: width of the runtime gap setting
- `ADDR_W`, $clog2(DEPTH): derived; not overridden

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  ADDR_W  buffer write address
- `wr_real`, `wr_imag`  in  WIDTH each  sample written at `wr_addr`
- `start`  in  1  begin streaming; sampled only in IDLE
- `stop`  in  1  end streaming after the current sample is accepted
- `loop`  in  1  wrap to sample 0 after the last sample instead of finishing; sampled at start
- `len`  in  ADDR_W+1  samples per pass; sampled at start
- `gap`  in  GAP_W  idle cycles between samples; sampled at start
- `ready`  in  1  downstream accepts the sample this cycle
- `en`  out  1  output sample valid (drives receiver `en`)
- `dout_real`, `dout_imag`  out  WIDTH each  output sample
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a non-loop pass completes or a stop takes effect

## Operation
- Buffer: DEPTH×(2·WIDTH) register array, not reset. Write occurs on `wr_en`, in any state. Read is combinational from index `idx` and is captured into the output registers. A same-cycle write and capture at the same address captures the old data.
- State machine:
  - IDLE → SEND when `start`=1 and `len`≠0. `start` with `len`=0 is ignored.
  - Entering SEND loads `idx`=0, latches `loop`/`gap`, and clamps `len` to DEPTH.
  - SEND: `en`=1 and `dout` holds `buf[idx]`. `en` and `dout` stay unchanged while `ready`=0.
  - On acceptance (`en`&`ready`):
    - `stop` active at acceptance, or latched pending, or last sample (`idx`=len−1) with loop=0 → DONE.
    - Otherwise `idx` advances, wrapping to 0 after len−1 when loop=1. Next state is GAP if `gap`≠0, else SEND.
  - GAP: `en`=0, `dout` holds the last sample, counter runs `gap` cycles, then → SEND with the next sample.
  - DONE: `done`=1 for one cycle, `en`=0 → IDLE.
- `stop` asserted in GAP is latched. The stream ends at the next acceptance, so that sample is still delivered. `stop` in IDLE has no effect.
- `start` while busy is ignored.
- Async reset mid-stream forces IDLE immediately. The stream is not resumed.
- Reset values: `en`=0, `dout_real`=0, `dout_imag`=0, `busy`=0, `done`=0, `idx`=0, gap counter 0, pending-stop 0.

## Timing
- Start latency: `start` sampled at edge t0 → `en`=1 with sample 0 from t0+1.
- With `ready` held high, sample k is presented at cycle t0+1+k·(gap+1), for exactly one cycle. `gap`=1 gives the alternating-`en` pattern the receiver is characterised with.
- Back-to-back streaming with `gap`=0: one sample per cycle, `en` continuously high.
- Last acceptance at edge tL → `done`=1 during tL+1, and `busy`=0 from tL+2.
- `busy` rises in the cycle after `start` is sampled.
- `ready` is a don't-care while `en`=0.

## Test plan
- Load buffer with real=k, imag=−k for k=0..7; len=8, gap=1, loop=0, `ready`=1, pulse start → `en` toggles 1,0,1,0…; outputs 0..7 on the `en`=1 cycles; one `done` pulse; `busy` drops; exactly 8 `en`-high cycles.
- Same load with gap=0 and `ready` low on alternate cycles → each sample held until accepted; no sample skipped or duplicated; total of 8 accepted.
- len=3, loop=1, gap=2 → sequence 0,1,2,0,1,2…, with 2 idle cycles between samples; assert `stop` during a GAP cycle → the next sample is delivered, then `done`; no further `en`.
- len=0 start → stays IDLE with `busy`=0. len=DEPTH+1 (when DEPTH < 2^ADDR_W+1 allows) clamps to DEPTH samples. `start` during busy is ignored.
- Deassert `rst_n` while streaming in SEND → `en`, `dout`, `busy`, `done` go to 0 immediately. After release, a new start replays from sample 0.
- Write buffer[idx+1] during the GAP before that sample is read → the new value is streamed. A write to the captured address in the capture cycle → the old value is streamed.
